// File: rtl/counter_apb_regs_if.sv
// APB3 bus bundle for the counter register bank; member names keep the slave-side view.
interface counter_apb_regs_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  i_psel;
    logic                  i_penable;
    logic                  i_pwrite;
    logic [ADDR_WIDTH-1:0] i_paddr;
    logic [31:0]           i_pwdata;
    logic [31:0]           o_prdata;
    logic                  o_pready;
    logic                  o_pslverr;

    modport master (
        output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
        input  o_prdata, o_pready, o_pslverr
    );

    modport slave (
        input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
        output o_prdata, o_pready, o_pslverr
    );
endinterface

// File: rtl/counter_apb_regs.sv
// APB3 register bank for one counter channel: control/target registers, stretched
// trigger and shiftout strobes, capture readback and edge-latched interrupt status.
module counter_apb_regs #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned STRETCH    = 4
) (
    input  logic              i_pclk,
    input  logic              i_prst,
    counter_apb_regs_if.slave apb,
    output logic              o_enable,
    output logic [2:0]        o_mode_sel,
    output logic [3:0]        o_ctrl_snap,
    output logic [3:0]        o_single_trigger,
    output logic [5:0]        o_target_reg_ctrl,
    output logic [31:0]       o_target_reg_a0,
    output logic [31:0]       o_target_reg_a1,
    output logic [31:0]       o_target_reg_a2,
    output logic [31:0]       o_target_reg_b0,
    output logic [31:0]       o_target_reg_b1,
    output logic [31:0]       o_target_reg_b2,
    input  logic [31:0]       i_shadow_reg,
    input  logic [5:0]        i_capture_reg_status,
    input  logic [31:0]       i_capture_reg_a0,
    input  logic [31:0]       i_capture_reg_a1,
    input  logic [31:0]       i_capture_reg_a2,
    input  logic [31:0]       i_capture_reg_b0,
    input  logic [31:0]       i_capture_reg_b1,
    input  logic [31:0]       i_capture_reg_b2,
    output logic [5:0]        o_capture_reg_read_flag,
    output logic [31:0]       o_shiftout_data,
    output logic              o_shiftout_data_valid,
    input  logic [31:0]       i_shiftin_data,
    input  logic [7:0]        i_int,
    output logic              o_irq
);
    localparam int unsigned CW = $clog2(STRETCH + 1);
    localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH);

    localparam logic [ADDR_WIDTH-1:0] A_CTRL     = ADDR_WIDTH'('h00);
    localparam logic [ADDR_WIDTH-1:0] A_TRIG     = ADDR_WIDTH'('h04);
    localparam logic [ADDR_WIDTH-1:0] A_TGT_CTRL = ADDR_WIDTH'('h08);
    localparam logic [ADDR_WIDTH-1:0] A_TGT_A0   = ADDR_WIDTH'('h0C);
    localparam logic [ADDR_WIDTH-1:0] A_TGT_A1   = ADDR_WIDTH'('h10);
    localparam logic [ADDR_WIDTH-1:0] A_TGT_A2   = ADDR_WIDTH'('h14);
    localparam logic [ADDR_WIDTH-1:0] A_TGT_B0   = ADDR_WIDTH'('h18);
    localparam logic [ADDR_WIDTH-1:0] A_TGT_B1   = ADDR_WIDTH'('h1C);
    localparam logic [ADDR_WIDTH-1:0] A_TGT_B2   = ADDR_WIDTH'('h20);
    localparam logic [ADDR_WIDTH-1:0] A_CAP_STAT = ADDR_WIDTH'('h24);
    localparam logic [ADDR_WIDTH-1:0] A_CAP_A0   = ADDR_WIDTH'('h28);
    localparam logic [ADDR_WIDTH-1:0] A_CAP_A1   = ADDR_WIDTH'('h2C);
    localparam logic [ADDR_WIDTH-1:0] A_CAP_A2   = ADDR_WIDTH'('h30);
    localparam logic [ADDR_WIDTH-1:0] A_CAP_B0   = ADDR_WIDTH'('h34);
    localparam logic [ADDR_WIDTH-1:0] A_CAP_B1   = ADDR_WIDTH'('h38);
    localparam logic [ADDR_WIDTH-1:0] A_CAP_B2   = ADDR_WIDTH'('h3C);
    localparam logic [ADDR_WIDTH-1:0] A_SHIFTOUT = ADDR_WIDTH'('h40);
    localparam logic [ADDR_WIDTH-1:0] A_SHIFTIN  = ADDR_WIDTH'('h44);
    localparam logic [ADDR_WIDTH-1:0] A_SHADOW   = ADDR_WIDTH'('h48);
    localparam logic [ADDR_WIDTH-1:0] A_INT_STAT = ADDR_WIDTH'('h4C);
    localparam logic [ADDR_WIDTH-1:0] A_INT_EN   = ADDR_WIDTH'('h50);

    logic [7:0]    r_ctrl;
    logic [5:0]    r_tgt_ctrl;
    logic [31:0]   r_tgt [6];
    logic [CW-1:0] r_trig_cnt [4];
    logic [CW-1:0] r_so_cnt;
    logic [31:0]   r_so_data;
    logic [5:0]    r_cap_flag;
    logic [7:0]    r_int_prev;
    logic [7:0]    r_int_status;
    logic [7:0]    r_int_en;
    logic          r_irq;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [31:0]           w_rdata;
    logic                  w_mapped;
    logic                  w_ro;
    logic [5:0]            w_cap_hit;
    logic [5:0]            w_tgt_hit;
    logic                  w_access;
    logic                  w_err;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_so_busy;
    logic                  w_trig_wr;
    logic [7:0]            w_int_clr;

    assign w_addr    = apb.i_paddr;
    assign w_so_busy = (r_so_cnt != '0);

    always_comb begin
        w_rdata   = '0;
        w_mapped  = 1'b1;
        w_ro      = 1'b0;
        w_cap_hit = '0;
        w_tgt_hit = '0;
        case (w_addr)
            A_CTRL:     w_rdata = {24'd0, r_ctrl};
            A_TRIG:     w_rdata = '0;
            A_TGT_CTRL: w_rdata = {26'd0, r_tgt_ctrl};
            A_TGT_A0:   begin w_rdata = r_tgt[0]; w_tgt_hit = 6'b000001; end
            A_TGT_A1:   begin w_rdata = r_tgt[1]; w_tgt_hit = 6'b000010; end
            A_TGT_A2:   begin w_rdata = r_tgt[2]; w_tgt_hit = 6'b000100; end
            A_TGT_B0:   begin w_rdata = r_tgt[3]; w_tgt_hit = 6'b001000; end
            A_TGT_B1:   begin w_rdata = r_tgt[4]; w_tgt_hit = 6'b010000; end
            A_TGT_B2:   begin w_rdata = r_tgt[5]; w_tgt_hit = 6'b100000; end
            A_CAP_STAT: begin w_rdata = {26'd0, i_capture_reg_status}; w_ro = 1'b1; end
            A_CAP_A0:   begin w_rdata = i_capture_reg_a0; w_ro = 1'b1; w_cap_hit = 6'b000001; end
            A_CAP_A1:   begin w_rdata = i_capture_reg_a1; w_ro = 1'b1; w_cap_hit = 6'b000010; end
            A_CAP_A2:   begin w_rdata = i_capture_reg_a2; w_ro = 1'b1; w_cap_hit = 6'b000100; end
            A_CAP_B0:   begin w_rdata = i_capture_reg_b0; w_ro = 1'b1; w_cap_hit = 6'b001000; end
            A_CAP_B1:   begin w_rdata = i_capture_reg_b1; w_ro = 1'b1; w_cap_hit = 6'b010000; end
            A_CAP_B2:   begin w_rdata = i_capture_reg_b2; w_ro = 1'b1; w_cap_hit = 6'b100000; end
            A_SHIFTOUT: w_rdata = {31'd0, w_so_busy};
            A_SHIFTIN:  begin w_rdata = i_shiftin_data; w_ro = 1'b1; end
            A_SHADOW:   begin w_rdata = i_shadow_reg; w_ro = 1'b1; end
            A_INT_STAT: w_rdata = {24'd0, r_int_status};
            A_INT_EN:   w_rdata = {24'd0, r_int_en};
            default:    w_mapped = 1'b0;
        endcase
    end

    // Any error suppresses every side effect of the transfer, including capture strobes.
    assign w_access  = apb.i_psel & apb.i_penable;
    assign w_err     = w_access & (~w_mapped |
                       (apb.i_pwrite & (w_ro | ((w_addr == A_SHIFTOUT) & w_so_busy))));
    assign w_wr      = w_access & apb.i_pwrite & ~w_err;
    assign w_rd      = w_access & ~apb.i_pwrite & ~w_err;
    assign w_trig_wr = w_wr & (w_addr == A_TRIG);
    assign w_int_clr = (w_wr && (w_addr == A_INT_STAT)) ? apb.i_pwdata[7:0] : '0;

    assign apb.o_prdata  = (w_access & ~apb.i_pwrite) ? w_rdata : '0;
    assign apb.o_pready  = 1'b1;
    assign apb.o_pslverr = w_err;

    always_ff @(posedge i_pclk or posedge i_prst) begin
        if (i_prst) begin
            r_ctrl     <= '0;
            r_tgt_ctrl <= '0;
            r_int_en   <= '0;
            r_so_data  <= '0;
            for (int unsigned i = 0; i < 6; i++) r_tgt[i] <= '0;
        end else if (w_wr) begin
            if (w_addr == A_CTRL)     r_ctrl     <= apb.i_pwdata[7:0];
            if (w_addr == A_TGT_CTRL) r_tgt_ctrl <= apb.i_pwdata[5:0];
            if (w_addr == A_INT_EN)   r_int_en   <= apb.i_pwdata[7:0];
            if (w_addr == A_SHIFTOUT) r_so_data  <= apb.i_pwdata;
            for (int unsigned i = 0; i < 6; i++) begin
                if (w_tgt_hit[i]) r_tgt[i] <= apb.i_pwdata;
            end
        end
    end

    always_ff @(posedge i_pclk or posedge i_prst) begin
        if (i_prst) begin
            for (int unsigned k = 0; k < 4; k++) r_trig_cnt[k] <= '0;
            r_so_cnt <= '0;
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (w_trig_wr && apb.i_pwdata[k]) r_trig_cnt[k] <= STRETCH_LOAD;
                else if (r_trig_cnt[k] != '0)      r_trig_cnt[k] <= r_trig_cnt[k] - 1'b1;
            end
            if (w_wr && (w_addr == A_SHIFTOUT)) r_so_cnt <= STRETCH_LOAD;
            else if (w_so_busy)                 r_so_cnt <= r_so_cnt - 1'b1;
        end
    end

    // New rising edges are OR-ed in after the W1C mask so a coincident set wins.
    always_ff @(posedge i_pclk or posedge i_prst) begin
        if (i_prst) begin
            r_int_prev   <= '0;
            r_int_status <= '0;
            r_irq        <= 1'b0;
            r_cap_flag   <= '0;
        end else begin
            r_int_prev   <= i_int;
            r_int_status <= (r_int_status & ~w_int_clr) | (i_int & ~r_int_prev);
            r_irq        <= |(r_int_status & r_int_en);
            r_cap_flag   <= w_rd ? w_cap_hit : '0;
        end
    end

    always_comb begin
        o_single_trigger = '0;
        for (int unsigned k = 0; k < 4; k++) o_single_trigger[k] = (r_trig_cnt[k] != '0);
    end

    assign o_enable                = r_ctrl[0];
    assign o_mode_sel              = r_ctrl[3:1];
    assign o_ctrl_snap             = r_ctrl[7:4];
    assign o_target_reg_ctrl       = r_tgt_ctrl;
    assign o_target_reg_a0         = r_tgt[0];
    assign o_target_reg_a1         = r_tgt[1];
    assign o_target_reg_a2         = r_tgt[2];
    assign o_target_reg_b0         = r_tgt[3];
    assign o_target_reg_b1         = r_tgt[4];
    assign o_target_reg_b2         = r_tgt[5];
    assign o_capture_reg_read_flag = r_cap_flag;
    assign o_shiftout_data         = r_so_data;
    assign o_shiftout_data_valid   = w_so_busy;
    assign o_irq                   = r_irq;
endmodule

// File: doc/counter_apb_regs.md
Name: counter_apb_regs

Overview:
APB3 slave register bank for one counter channel. It is the bus-side end of the counter configuration/status interface. It drives the channel's enable, mode, target, trigger and shiftout controls. It returns shadow, capture, shiftin and interrupt state to software. One instance per channel sits in the i_pclk domain; the counter-side synchronizers consume its outputs.

Parameters:
ADDR_WIDTH, 8, PADDR width (byte address; word-aligned registers).
STRETCH, 4, cycles each trigger/valid pulse is held high (≥3 so the destination synchronizer catches it).

Ports:
i_pclk  in  1  register clock.
i_prst  in  1  asynchronous reset, active-high.
i_psel  in  1  APB select.
i_penable  in  1  APB access phase.
i_pwrite  in  1  1=write.
i_paddr  in  ADDR_WIDTH  byte address.
i_pwdata  in  32  write data.
o_prdata  out  32  read data.
o_pready  out  1  transfer complete.
o_pslverr  out  1  error response.
o_enable  out  1  CTRL[0].
o_mode_sel  out  3  CTRL[3:1].
o_ctrl_snap  out  4  CTRL[7:4].
o_single_trigger  out  4  stretched {start,stop,clear,reset}.
o_target_reg_ctrl  out  6  TGT_CTRL[5:0].
o_target_reg_a0..a2, o_target_reg_b0..b2  out  32 each  target registers.
i_shadow_reg  in  32  counter shadow value.
i_capture_reg_status  in  6  capture-valid flags.
i_capture_reg_a0..a2, i_capture_reg_b0..b2  in  32 each  capture values.
o_capture_reg_read_flag  out  6  one-cycle read strobes.
o_shiftout_data  out  32  shiftout word.
o_shiftout_data_valid  out  1  stretched valid.
i_shiftin_data  in  32  shiftin word.
i_int  in  8  counter interrupt sources (level).
o_irq  out  1  aggregated interrupt.

Behaviour:
- All i_* status inputs are synchronous to i_pclk; no synchronizers in this block.
- Reset: all registers 0, o_prdata=0, o_pslverr=0, stretch counters 0, o_irq=0, int-history flops 0. o_pready=1.
- APB timing:
  - Zero wait states; o_pready is always 1.
  - A write commits at the access-phase edge (psel&penable&pwrite).
  - A read drives o_prdata combinationally during the access phase. o_prdata is 0 when not in an access phase.
- Map:
  - 0x00 CTRL (RW, bits[7:0]).
  - 0x04 TRIG (WO; write-1 bits[3:0]; reads 0).
  - 0x08 TGT_CTRL (RW [5:0]).
  - 0x0C/10/14 TGT_A0/A1/A2 (RW); 0x18/1C/20 TGT_B0/B1/B2 (RW).
  - 0x24 CAP_STATUS (RO).
  - 0x28/2C/30 CAP_A0/A1/A2 (RO); 0x34/38/3C CAP_B0/B1/B2 (RO).
  - 0x40 SHIFTOUT (WO data; reads the busy flag in bit0).
  - 0x44 SHIFTIN (RO).
  - 0x48 SHADOW (RO).
  - 0x4C INT_STATUS (RW1C [7:0]); 0x50 INT_EN (RW [7:0]).
- Unused bits read 0.
- o_pslverr=1 in the access phase for:
  - an unmapped address;
  - a write to a RO register;
  - a SHIFTOUT write while busy.
- An error transfer has no side effects.
- TRIG:
  - Writing a 1 to bit k loads that bit's counter with STRETCH. o_single_trigger[k]=1 while its counter≠0. The counter decrements each cycle.
  - A rewrite while active reloads the counter; there is no gap.
  - Output is high exactly STRETCH cycles after a single write, starting the cycle after the write edge.
- Capture read strobe: an error-free read of CAP_xn asserts the matching o_capture_reg_read_flag bit for exactly one cycle after the access edge. Bit mapping is a0..a2=[2:0], b0..b2=[5:3].
- SHIFTOUT:
  - Write latches o_shiftout_data and sets busy.
  - o_shiftout_data_valid=1 for STRETCH cycles; busy clears when valid drops.
  - o_shiftout_data is held until the next write.
- Interrupts:
  - int_prev<=i_int each cycle. INT_STATUS[k] sets on a rising edge of i_int[k].
  - W1C clears a bit. If a set and a clear occur in the same cycle, set wins.
  - o_irq = registered |(INT_STATUS & INT_EN); this adds 1 cycle of latency.
- Reset asserted mid-operation aborts active stretches: outputs drop in the same cycle (asynchronous) and busy clears.

Test Plan:
- Reset → CTRL/TGT reads 0, o_pready=1, o_irq=0. Write CTRL=0xA5 → o_enable=1, o_mode_sel=3'b010, o_ctrl_snap=4'hA; readback 0x000000A5.
- Write TRIG=0x5 → o_single_trigger=4'b0101 for exactly 4 cycles, then 0. Rewrite after 2 cycles → high for 6 cycles total.
- i_capture_reg_b1=0xDEADBEEF; read 0x38 → prdata=0xDEADBEEF, o_capture_reg_read_flag=6'b010000 for 1 cycle. Read 0x3C with psel low → no strobe.
- Write SHIFTOUT=0x12345678 → valid 4 cycles, data stable. A second write during busy → pslverr=1, data unchanged. After valid drops, read 0x40 → 0.
- i_int[3] rises, INT_EN=0x08 → INT_STATUS=0x08, o_irq=1 one cycle later. W1C 0x08 coinciding with a new rise → bit stays 1.
- Access 0x60 → pslverr=1, prdata=0. Write 0x24 → pslverr=1. Assert i_prst during a TRIG stretch → o_single_trigger=0 immediately.
